// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multiport integer register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   reg_addr_t           : register address at the default register count
//   ZERO_REG             : hardwired-zero register index
//   wr_winner()          : picks the highest-index asserted write port
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  // Upper bound on write ports handled by the priority helper.
  localparam int unsigned MAX_WR = 16;
  localparam int unsigned PW     = $clog2(MAX_WR);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

  typedef logic [MAX_WR-1:0] wr_hit_t;

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] port;
  } wr_sel_t;

  // Highest-index hit wins: later loop iterations override earlier ones.
  function automatic wr_sel_t wr_winner(input wr_hit_t hits);
    wr_sel_t sel;
    sel = '0;
    for (int unsigned p = 0; p < MAX_WR; p++) begin
      if (hits[p]) begin
        sel.valid = 1'b1;
        sel.port  = PW'(p);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write-back.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   set_vec      : one-hot(ish) issue mask
//   clr_vec      : registers written back this cycle
//   busy_next_c  : combinational next state (what the bits become at this edge)
module regfile_scoreboard #(
  parameter int unsigned NREGS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NREGS-1:0] set_vec,
  input  logic [NREGS-1:0] clr_vec,
  output logic [NREGS-1:0] busy_next_c
);

  logic [NREGS-1:0] busy_q;

  // Set applied after clear so a newly issued producer outranks an older write-back.
  always_comb begin
    busy_next_c    = (busy_q & ~clr_vec) | set_vec;
    busy_next_c[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next_c;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport integer register file for the ID stage.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   rd_en        : 1 = load read outputs, 0 = hold (stall)
//   rd_addr      : NRD packed read addresses
//   rd_data      : NRD packed registered read data
//   rd_busy      : NRD registered pending-write flags of the addressed registers
//   wr_en/addr/data : NWR write ports, higher index has priority
//   sb_set, sb_addr : mark a register as having a pending write
//   dbg_addr, dbg_data : combinational observation port
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NRD    = 2,
  parameter  int unsigned NWR    = 2,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0]  regs    [NREGS];
  logic [XLEN-1:0]  wb_data [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] sb_set_vec;
  logic [NREGS-1:0] sb_next;
  logic [NRD*XLEN-1:0] rd_data_d;
  logic [NRD-1:0]      rd_busy_d;

  // Register 0 has no storage and never matches a write.
  assign regs[0]    = '0;
  assign wb_data[0] = '0;
  assign wr_hit[0]  = 1'b0;

  // Per-register write decode, priority select and storage.
  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    wr_hit_t         hit;
    wr_sel_t         sel;
    logic [XLEN-1:0] q;

    always_comb begin
      hit = '0;
      for (int unsigned p = 0; p < NWR; p++) begin
        hit[p] = wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r));
      end
    end

    assign sel        = wr_winner(hit);
    assign wr_hit[r]  = sel.valid;
    assign wb_data[r] = wr_data[int'(sel.port)*XLEN +: XLEN];
    assign regs[r]    = q;

    always_ff @(posedge clock) begin
      if (reset) begin
        q <= '0;
      end else if (sel.valid) begin
        q <= wb_data[r];
      end
    end
  end

  // Issue mask; register 0 can never become busy.
  always_comb begin
    sb_set_vec = '0;
    if (sb_set && (sb_addr != AW'(ZERO_REG))) begin
      sb_set_vec[sb_addr] = 1'b1;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .set_vec     (sb_set_vec),
    .clr_vec     (wr_hit),
    .busy_next_c (sb_next)
  );

  // Read muxes; busy comes from scoreboard next state so a same-cycle write-back reads as ready.
  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      if ((BYPASS != 0) && wr_hit[rd_addr[k*AW +: AW]]) begin
        rd_data_d[k*XLEN +: XLEN] = wb_data[rd_addr[k*AW +: AW]];
      end else begin
        rd_data_d[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
      end
      rd_busy_d[k] = sb_next[rd_addr[k*AW +: AW]];
    end
  end

  // Read-stage output registers; reset overrides a stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else if (rd_en) begin
      rd_data <= rd_data_d;
      rd_busy <= rd_busy_d;
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: BYPASS=1 and BYPASS=0 instances on shared stimulus,
// directed vectors with literal expectations plus a reference model checked every cycle.
module tb_regfile_multiport;
  import regfile_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRD   = 3;
  localparam int unsigned NWR   = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic                rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0]      rd_busy, rd_busy_nb;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                sb_set;
  reg_addr_t           sb_addr;
  reg_addr_t           dbg_addr;
  logic [XLEN-1:0]     dbg_data, dbg_data_nb;

  always #5 clock = ~clock;

  regfile_multiport #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)
  ) dut (
    .clock(clock), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_multiport #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)
  ) dut_nb (
    .clock(clock), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_nb), .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [63:0]      mem [NREGS];
  logic [NREGS-1:0] sb;
  logic [63:0]      e_rd    [NRD];
  logic [63:0]      e_rd_nb [NRD];
  logic [NRD-1:0]   e_busy;

  function automatic logic [63:0] rdo(input int k);
    return rd_data[k*XLEN +: XLEN];
  endfunction

  function automatic logic [63:0] rdn(input int k);
    return rd_data_nb[k*XLEN +: XLEN];
  endfunction

  task automatic model_edge();
    logic [NREGS-1:0] nsb;
    logic [AW-1:0]    a;
    logic [63:0]      byp;
    if (reset) begin
      for (int r = 0; r < NREGS; r++) mem[r] = 64'd0;
      sb = '0;
      for (int k = 0; k < NRD; k++) begin
        e_rd[k]    = 64'd0;
        e_rd_nb[k] = 64'd0;
      end
      e_busy = '0;
      return;
    end
    nsb = sb;
    for (int p = 0; p < NWR; p++)
      if (wr_en[p]) nsb[wr_addr[p*AW +: AW]] = 1'b0;
    if (sb_set) nsb[sb_addr] = 1'b1;
    nsb[0] = 1'b0;
    if (rd_en) begin
      for (int k = 0; k < NRD; k++) begin
        a   = rd_addr[k*AW +: AW];
        byp = mem[a];
        e_rd_nb[k] = mem[a];
        for (int p = 0; p < NWR; p++)
          if (wr_en[p] && wr_addr[p*AW +: AW] == a && a != 5'd0) byp = wr_data[p*XLEN +: XLEN];
        e_rd[k]   = byp;
        e_busy[k] = nsb[a];
      end
    end
    for (int p = 0; p < NWR; p++)
      if (wr_en[p] && wr_addr[p*AW +: AW] != 5'd0) mem[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
    sb = nsb;
  endtask

  task automatic compare_all();
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("m_rd%0d", k),      rdo(k), e_rd[k]);
      check($sformatf("m_rdnb%0d", k),    rdn(k), e_rd_nb[k]);
      check($sformatf("m_busy%0d", k),    64'(rd_busy[k]), 64'(e_busy[k]));
      check($sformatf("m_busynb%0d", k),  64'(rd_busy_nb[k]), 64'(e_busy[k]));
    end
    check("m_dbg",   dbg_data,    mem[dbg_addr]);
    check("m_dbgnb", dbg_data_nb, mem[dbg_addr]);
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic idle();
    reset    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    sb_set   = 1'b0;
    sb_addr  = '0;
    dbg_addr = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [63:0] d);
    wr_en[p]               = 1'b1;
    wr_addr[p*AW +: AW]    = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int k, input logic [AW-1:0] a);
    rd_en               = 1'b1;
    rd_addr[k*AW +: AW] = a;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    check("rst_rd0",  rdo(0), 64'd0);
    check("rst_busy", 64'(rd_busy), 64'd0);

    // Write then reset clears storage, outputs and scoreboard
    idle(); wr(0, 5'd5, 64'hDEAD); sb_set = 1'b1; sb_addr = 5'd5; dbg_addr = 5'd5;
    step();
    check("wr_x5", dbg_data, 64'hDEAD);
    idle(); reset = 1'b1; dbg_addr = 5'd5;
    step();
    check("rst_x5", dbg_data, 64'd0);
    idle(); rd(0, 5'd5);
    step();
    check("rst_sb", 64'(rd_busy[0]), 64'd0);
    check("rst_rd5", rdo(0), 64'd0);

    // Register 0 is hardwired
    idle(); wr(0, 5'd0, 64'hFFFF); rd(0, 5'd0);
    step();
    check("x0_byp",   rdo(0), 64'd0);
    check("x0_bypnb", rdn(0), 64'd0);
    idle(); rd(0, 5'd0); dbg_addr = 5'd0;
    step();
    check("x0_rd",  rdo(0), 64'd0);
    check("x0_dbg", dbg_data, 64'd0);
    idle(); sb_set = 1'b1; sb_addr = 5'd0; rd(0, 5'd0);
    step();
    check("x0_busy", 64'(rd_busy[0]), 64'd0);
    idle(); rd(0, 5'd0);
    step();
    check("x0_busy2", 64'(rd_busy[0]), 64'd0);

    // Same-address write conflict: higher port wins
    idle(); wr(0, 5'd7, 64'h5);
    step();
    idle(); wr(0, 5'd7, 64'h11); wr(1, 5'd7, 64'h22); rd(1, 5'd7); dbg_addr = 5'd7;
    step();
    check("cf_dbg",   dbg_data, 64'h22);
    check("cf_byp",   rdo(1), 64'h22);
    check("cf_nobyp", rdn(1), 64'h5);

    // Stall holds read outputs
    idle(); wr(0, 5'd3, 64'h33);
    step();
    idle(); rd(0, 5'd3);
    step();
    check("st_rd", rdo(0), 64'h33);
    for (int i = 0; i < 3; i++) begin
      idle();
      if (i == 0) wr(0, 5'd3, 64'h44);
      step();
      check("st_hold", rdo(0), 64'h33);
    end
    idle(); rd(0, 5'd3);
    step();
    check("st_new", rdo(0), 64'h44);

    // Scoreboard set/clear interaction
    idle(); sb_set = 1'b1; sb_addr = 5'd9; rd(0, 5'd9);
    step();
    check("sb_set", 64'(rd_busy[0]), 64'd1);
    idle(); wr(0, 5'd9, 64'h98); sb_set = 1'b1; sb_addr = 5'd9; rd(0, 5'd9);
    step();
    check("sb_both",  64'(rd_busy[0]), 64'd1);
    check("sb_bothd", rdo(0), 64'h98);
    idle(); wr(1, 5'd9, 64'h99); rd(0, 5'd9); rd(2, 5'd9);
    step();
    check("sb_clr",    64'(rd_busy[0]), 64'd0);
    check("sb_data",   rdo(0), 64'h99);
    check("sb_nb",     rdn(0), 64'h98);
    check("sb_same",   rdo(2), 64'h99);
    check("sb_same_b", 64'(rd_busy[2]), 64'd0);

    // Reset during a stall clears outputs
    idle(); sb_set = 1'b1; sb_addr = 5'd4; rd(1, 5'd4);
    step();
    check("rs_busy1", 64'(rd_busy[1]), 64'd1);
    idle(); reset = 1'b1;
    step();
    check("rs_busy", 64'(rd_busy), 64'd0);
    check("rs_rd0",  rdo(0), 64'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      reset  = ($urandom_range(0, 499) == 0);
      rd_en  = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NRD; k++)
        rd_addr[k*AW +: AW] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      for (int p = 0; p < NWR; p++) begin
        wr_en[p]                = ($urandom_range(0, 2) != 0);
        wr_addr[p*AW +: AW]     = 5'($urandom_range(0, 7));
        wr_data[p*XLEN +: XLEN] = {$urandom, $urandom};
      end
      sb_set   = ($urandom_range(0, 1) != 0);
      sb_addr  = 5'($urandom_range(0, 7));
      dbg_addr = 5'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
